fft_fifo_axis_reader: RTL

Read-side controller for the FFT sample FIFO (sync FIFO, 16-bit words, depth 2**10, water-level outputs). It waits until a full FFT frame is buffered. It then drains exactly FRAME_LEN words through the FIFO read port and presents them as an AXI4-Stream master with tlast on the final word. It is the consumer end of the FIFO whose producer is the ADC/write path, and it feeds the FFT core input.

---
 rtl/fft_fifo_axis_reader_pkg.sv | 17 +
 rtl/fft_fifo_axis_reader_skid_buf.sv | 43 ++++
 rtl/fft_fifo_axis_reader.sv | 111 +++++++++++
 3 files changed

// File: rtl/fft_fifo_axis_reader_pkg.sv
// rtl/fft_fifo_axis_reader_pkg.sv - shared types and constants for the FFT FIFO reader
package fft_fifo_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2
   } state_t;

   localparam int DEF_DATA_WIDTH  = 16;
   localparam int DEF_DEPTH_WIDTH = 10;

   function automatic bit frame_len_ok(input int frame_len, input int depth_width);
      return (frame_len >= 2) && (frame_len <= (1 << depth_width));
   endfunction

endpackage

// File: rtl/fft_fifo_axis_reader_skid_buf.sv
// rtl/fft_fifo_axis_reader_skid_buf.sv - 2-entry register FIFO holding {last, data}
module axis_skid_buf_2 #(
   parameter int WIDTH = 17
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [1:0]       occ,
   output logic             head_valid,
   output logic [WIDTH-1:0] head_data
);

   logic [WIDTH-1:0] entry0;
   logic [WIDTH-1:0] entry1;
   logic [1:0]       wr_slot;

   // Slot for an incoming word after any same-cycle pop has shifted entry1 down.
   assign wr_slot = occ - {1'b0, pop};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         entry0 <= '0;
         entry1 <= '0;
         occ    <= 2'd0;
      end else begin
         if (pop)
            entry0 <= entry1;
         if (push) begin
            if (wr_slot == 2'd0)
               entry0 <= push_data;
            else
               entry1 <= push_data;
         end
         occ <= occ + {1'b0, push} - {1'b0, pop};
      end
   end

   assign head_valid = (occ != 2'd0);
   assign head_data  = entry0;

endmodule

// File: rtl/fft_fifo_axis_reader.sv
// rtl/fft_fifo_axis_reader.sv - drains one FFT frame per trigger from the sample FIFO onto an AXI4-Stream master
module fft_fifo_axis_reader
   import fft_fifo_pkg::*;
#(
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int DEPTH_WIDTH = DEF_DEPTH_WIDTH,
   parameter int FRAME_LEN   = 1024,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   input  logic                  fifo_rd_empty,
   input  logic [DEPTH_WIDTH:0]  fifo_rd_water_level,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic                  busy,
   output logic                  frame_done,
   output logic [CNT_WIDTH-1:0]  frame_cnt,
   output logic                  err_underrun
);

   if (!frame_len_ok(FRAME_LEN, DEPTH_WIDTH)) begin : g_bad_frame_len
      $error("FRAME_LEN must lie in 2..2**DEPTH_WIDTH");
   end

   localparam int                   IDX_W    = $clog2(FRAME_LEN + 1);
   localparam logic [IDX_W-1:0]     LEN_IDX  = IDX_W'(FRAME_LEN);
   localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(FRAME_LEN - 1);
   localparam logic [DEPTH_WIDTH:0] LEN_LVL  = (DEPTH_WIDTH + 1)'(FRAME_LEN);

   state_t                state;
   state_t                next_state;
   logic [IDX_W-1:0]      rd_idx;
   logic                  inflight;
   logic                  inflight_last;
   logic                  pop;
   logic                  credit_ok;
   logic                  issue_last;
   logic [1:0]            occ;
   logic                  head_valid;
   logic [DATA_WIDTH:0]   head_data;

   // A read may only be issued if the skid buffer is guaranteed a free slot when its data returns.
   assign credit_ok  = ({1'b0, occ} + {2'b0, inflight}) < (3'd2 + {2'b0, pop});
   assign fifo_rd_en = (state == STREAM) && (rd_idx < LEN_IDX) && !fifo_rd_empty && credit_ok;
   assign issue_last = fifo_rd_en && (rd_idx == LAST_IDX);

   assign pop           = head_valid && m_axis_tready;
   assign m_axis_tvalid = head_valid;
   assign m_axis_tdata  = head_data[DATA_WIDTH-1:0];
   assign m_axis_tlast  = head_valid && head_data[DATA_WIDTH];
   assign frame_done    = (state == DRAIN) && pop && head_data[DATA_WIDTH];
   assign busy          = (state != IDLE);

   axis_skid_buf_2 #(
      .WIDTH(DATA_WIDTH + 1)
   ) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (inflight),
      .push_data ({inflight_last, fifo_rd_data}),
      .pop       (pop),
      .occ       (occ),
      .head_valid(head_valid),
      .head_data (head_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (enable && (fifo_rd_water_level >= LEN_LVL)) next_state = STREAM;
         STREAM:  if (issue_last) next_state = DRAIN;
         DRAIN:   if (frame_done) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_idx        <= '0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
         frame_cnt     <= '0;
         err_underrun  <= 1'b0;
      end else begin
         if (state == IDLE)
            rd_idx <= '0;
         else if (fifo_rd_en)
            rd_idx <= rd_idx + IDX_W'(1);
         inflight      <= fifo_rd_en;
         inflight_last <= issue_last;
         if (frame_done)
            frame_cnt <= frame_cnt + CNT_WIDTH'(1);
         if ((state == STREAM) && (rd_idx < LEN_IDX) && fifo_rd_empty)
            err_underrun <= 1'b1;
      end
   end

endmodule
